// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared constants for the PS/2 key tracker: scan-code prefixes, key indices, FSM states.
`timescale 1ns/1ps
package ps2_key_state_tracker_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    // Pause sends E1 followed by seven more bytes that carry no key meaning
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_SPACEBAR  = 0;
    localparam int KEY_BACKSLASH = 1;
    localparam int KEY_A         = 2;
    localparam int KEY_S         = 3;
    localparam int KEY_D         = 4;
    localparam int KEY_F         = 5;
    localparam int KEY_J         = 6;
    localparam int KEY_K         = 7;
    localparam int KEY_L         = 8;
    localparam int KEY_SEMICOLON = 9;
    localparam int KEY_Q         = 10;
    localparam int KEY_W         = 11;
    localparam int KEY_E         = 12;
    localparam int KEY_R         = 13;
    localparam int KEY_U         = 14;
    localparam int KEY_I         = 15;
    localparam int KEY_O         = 16;
    localparam int KEY_P         = 17;
    localparam int KEY_Z         = 18;
    localparam int KEY_X         = 19;
    localparam int KEY_C         = 20;
    localparam int KEY_V         = 21;
    localparam int KEY_ENTER     = 22;
    localparam int KEY_LSHIFT    = 23;
    localparam int KEY_LCTRL     = 24;
    localparam int KEY_ESC       = 25;
    localparam int KEY_UP        = 26;
    localparam int KEY_DOWN      = 27;
    localparam int KEY_LEFT      = 28;
    localparam int KEY_RIGHT     = 29;
    localparam int KEY_RCTRL     = 30;
    localparam int KEY_RALT      = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0,
        ST_SKIP
    } ps2_state_t;

    // Keyboard housekeeping responses that never belong to a key sequence
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
               (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_state_tracker_keymap_lut.sv
// Combinational keyboard layout: (extended flag, set-2 code) -> (hit, key index).
`timescale 1ns/1ps
module ps2_keymap_lut
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int NUM_KEYS = 32,
    parameter int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic             ext,
    input  logic [7:0]       code,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic       found;
    logic [5:0] raw_idx;

    always_comb begin
        found   = 1'b1;
        raw_idx = '0;
        case ({ext, code})
            9'h029: raw_idx = 6'(KEY_SPACEBAR);
            9'h05D: raw_idx = 6'(KEY_BACKSLASH);
            9'h01C: raw_idx = 6'(KEY_A);
            9'h01B: raw_idx = 6'(KEY_S);
            9'h023: raw_idx = 6'(KEY_D);
            9'h02B: raw_idx = 6'(KEY_F);
            9'h03B: raw_idx = 6'(KEY_J);
            9'h042: raw_idx = 6'(KEY_K);
            9'h04B: raw_idx = 6'(KEY_L);
            9'h04C: raw_idx = 6'(KEY_SEMICOLON);
            9'h015: raw_idx = 6'(KEY_Q);
            9'h01D: raw_idx = 6'(KEY_W);
            9'h024: raw_idx = 6'(KEY_E);
            9'h02D: raw_idx = 6'(KEY_R);
            9'h03C: raw_idx = 6'(KEY_U);
            9'h043: raw_idx = 6'(KEY_I);
            9'h044: raw_idx = 6'(KEY_O);
            9'h04D: raw_idx = 6'(KEY_P);
            9'h01A: raw_idx = 6'(KEY_Z);
            9'h022: raw_idx = 6'(KEY_X);
            9'h021: raw_idx = 6'(KEY_C);
            9'h02A: raw_idx = 6'(KEY_V);
            9'h05A: raw_idx = 6'(KEY_ENTER);
            9'h012: raw_idx = 6'(KEY_LSHIFT);
            9'h014: raw_idx = 6'(KEY_LCTRL);
            9'h076: raw_idx = 6'(KEY_ESC);
            9'h175: raw_idx = 6'(KEY_UP);
            9'h172: raw_idx = 6'(KEY_DOWN);
            9'h16B: raw_idx = 6'(KEY_LEFT);
            9'h174: raw_idx = 6'(KEY_RIGHT);
            9'h114: raw_idx = 6'(KEY_RCTRL);
            9'h111: raw_idx = 6'(KEY_RALT);
            default: found = 1'b0;
        endcase
    end

    // Keys beyond a reduced NUM_KEYS are treated as unmapped
    assign hit = found && (int'(raw_idx) < NUM_KEYS);
    assign idx = IDX_W'(raw_idx);

endmodule

// File: rtl/ps2_key_state_tracker.sv
// PS/2 set-2 decoder: held-key vector plus a first-word-fall-through press/release event FIFO.
`timescale 1ns/1ps
module ps2_key_state_tracker
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int NUM_KEYS       = 32,
    parameter int EVT_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int IDX_W         = $clog2(NUM_KEYS),
    localparam int CNT_W         = $clog2(EVT_DEPTH + 1)
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                clear_all,
    input  logic [7:0]          scan_code,
    input  logic                scan_valid,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_press,
    output logic [IDX_W-1:0]    evt_index,
    output logic [CNT_W-1:0]    evt_count,
    output logic                overflow
);

    localparam int PTR_W = $clog2(EVT_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]          byte_reg;
    logic                byte_valid_reg;
    ps2_state_t          state_reg, state_next;
    logic [2:0]          skip_cnt_reg, skip_cnt_next;
    logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
    logic [NUM_KEYS-1:0] key_state_reg, key_state_next;

    logic                decode_en, decode_ext, decode_break;
    logic                lut_hit;
    logic [IDX_W-1:0]    lut_idx;
    logic                push_req, push_press;

    logic [IDX_W:0]      mem [EVT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                overflow_reg;
    logic                fifo_full, do_pop, do_push;

    ps2_keymap_lut #(.NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) u_keymap (
        .ext  (decode_ext),
        .code (byte_reg),
        .hit  (lut_hit),
        .idx  (lut_idx)
    );

    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        decode_en     = 1'b0;
        decode_ext    = 1'b0;
        decode_break  = 1'b0;
        if (byte_valid_reg) begin
            to_cnt_next = '0;
            if (!is_ignored(byte_reg)) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (byte_reg == SC_E0) begin
                            state_next = ST_GOT_E0;
                        end else if (byte_reg == SC_F0) begin
                            state_next = ST_GOT_F0;
                        end else if (byte_reg == SC_E1) begin
                            state_next    = ST_SKIP;
                            skip_cnt_next = PAUSE_SKIP;
                        end else begin
                            decode_en = 1'b1;
                        end
                    end
                    ST_GOT_E0: begin
                        if (byte_reg == SC_F0) begin
                            state_next = ST_GOT_E0F0;
                        end else if (byte_reg != SC_E0) begin
                            decode_en  = 1'b1;
                            decode_ext = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    ST_GOT_F0: begin
                        decode_en    = 1'b1;
                        decode_break = 1'b1;
                        state_next   = ST_IDLE;
                    end
                    ST_GOT_E0F0: begin
                        decode_en    = 1'b1;
                        decode_ext   = 1'b1;
                        decode_break = 1'b1;
                        state_next   = ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_cnt_next = skip_cnt_reg - 3'd1;
                        if (skip_cnt_next == 3'd0) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end else if (state_reg != ST_IDLE) begin
            // A half-received prefix is abandoned if the rest never arrives
            if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_next  = ST_IDLE;
                to_cnt_next = '0;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        key_state_next = key_state_reg;
        push_req       = 1'b0;
        push_press     = 1'b0;
        if (decode_en && lut_hit) begin
            if (!decode_break && !key_state_reg[lut_idx]) begin
                key_state_next[lut_idx] = 1'b1;
                push_req                = 1'b1;
                push_press              = 1'b1;
            end else if (decode_break && key_state_reg[lut_idx]) begin
                key_state_next[lut_idx] = 1'b0;
                push_req                = 1'b1;
            end
        end
    end

    assign fifo_full = (count_reg == CNT_W'(EVT_DEPTH));
    assign do_pop    = evt_ready && (count_reg != '0);
    assign do_push   = push_req && (!fifo_full || do_pop);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
            state_reg      <= ST_IDLE;
            skip_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            key_state_reg  <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else if (clear_all) begin
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
            state_reg      <= ST_IDLE;
            skip_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            key_state_reg  <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            byte_reg       <= scan_code;
            byte_valid_reg <= scan_valid;
            state_reg      <= state_next;
            skip_cnt_reg   <= skip_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            key_state_reg  <= key_state_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push_req && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid
    always_ff @(posedge CLOCK_50) begin
        if (do_push && !clear_all) begin
            mem[wr_ptr_reg] <= {push_press, lut_idx};
        end
    end

    assign key_state = key_state_reg;
    assign evt_valid = (count_reg != '0);
    assign evt_press = mem[rd_ptr_reg][IDX_W];
    assign evt_index = mem[rd_ptr_reg][IDX_W-1:0];
    assign evt_count = count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Scoreboard bench: stimulus pushes expected events, a monitor pops and compares on each FIFO pop.
`timescale 1ns/1ps
module tb_ps2_key_state_tracker;

    localparam int NK    = 32;
    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int IW    = 5;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clear_all = 1'b0;
    logic [7:0]    scan_code = '0;
    logic          scan_valid = 1'b0;
    logic          evt_ready = 1'b0;
    logic [NK-1:0] key_state;
    logic          evt_valid;
    logic          evt_press;
    logic [IW-1:0] evt_index;
    logic [CW-1:0] evt_count;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [IW:0] exp_q[$];

    ps2_key_state_tracker #(.NUM_KEYS(NK), .EVT_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .clear_all  (clear_all),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .key_state  (key_state),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_press  (evt_press),
        .evt_index  (evt_index),
        .evt_count  (evt_count),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted FIFO head is one transaction
    always @(negedge clk) begin
        if (resetn && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_evt: got press=%0d idx=%0d expected none", evt_press, evt_index);
            end else begin
                logic [IW:0] e;
                e = exp_q.pop_front();
                $display("EVT press=%0d idx=%0d (expected press=%0d idx=%0d)",
                         evt_press, evt_index, e[IW], e[IW-1:0]);
                check("evt", {26'd0, evt_press, evt_index}, {26'd0, e});
            end
        end
    end

    task automatic expect_evt(input logic press, input int idx);
        exp_q.push_back({press, IW'(idx)});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int i;
        evt_ready = 1'b1;
        settle();
        i = 0;
        while (evt_count != '0 && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        check({name, "_drained"}, 32'(evt_count), 32'd0);
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] fill_codes [9] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h15};
    logic [7:0] pause_seq  [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        #35;
        check("rst_key_state", key_state, 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_count", 32'(evt_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Space press and release, consumer stalled
        evt_ready = 1'b0;
        expect_evt(1'b1, 0);
        send(8'h29);
        settle();
        check("space_held", key_state, 32'h1);
        expect_evt(1'b0, 0);
        send(8'hF0);
        send(8'h29);
        settle();
        check("space_released", key_state, 32'h0);
        check("space_count", 32'(evt_count), 32'd2);
        wait_drain("space");

        // Typematic backslash
        expect_evt(1'b1, 1);
        repeat (5) send(8'h5D);
        settle();
        check("bslash_held", key_state, 32'h2);
        expect_evt(1'b0, 1);
        send(8'hF0);
        send(8'h5D);
        settle();
        check("bslash_released", key_state, 32'h0);
        wait_drain("bslash");

        // Extended Up vs unmapped KP8
        expect_evt(1'b1, 26);
        send(8'hE0);
        send(8'h75);
        settle();
        check("up_held", key_state, 32'h0400_0000);
        expect_evt(1'b0, 26);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        settle();
        check("up_released", key_state, 32'h0);
        send(8'h75);
        settle();
        check("kp8_ignored", key_state, 32'h0);
        wait_drain("up");

        // Pause sequence skipped, then decoder back in IDLE
        for (int i = 0; i < 8; i++) send(pause_seq[i]);
        settle();
        check("pause_keys", key_state, 32'h0);
        check("pause_count", 32'(evt_count), 32'd0);
        expect_evt(1'b1, 0);
        send(8'h29);
        expect_evt(1'b0, 0);
        send(8'hF0);
        send(8'h29);
        wait_drain("pause");

        // Overflow on a stalled FIFO
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) expect_evt(1'b1, i + 2);
            send(fill_codes[i]);
        end
        settle();
        check("full_count", 32'(evt_count), 32'd8);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_keys", key_state, 32'h0000_07FC);
        // Push and pop land on the same edge while full
        expect_evt(1'b1, 11);
        @(posedge clk); #1;
        scan_code  = 8'h1D;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        evt_ready  = 1'b1;
        @(posedge clk); #1;
        evt_ready  = 1'b0;
        check("pushpop_count", 32'(evt_count), 32'd8);
        check("pushpop_keys", key_state, 32'h0000_0FFC);
        wait_drain("overflow");
        check("overflow_sticky", 32'(overflow), 32'd1);

        // F0 still pending just before the timeout
        expect_evt(1'b0, 2);
        send(8'hF0);
        repeat (TO - 20) @(posedge clk);
        send(8'h1C);
        settle();
        check("pre_timeout_break", key_state, 32'h0000_0FF8);
        wait_drain("pre_timeout");

        // F0 abandoned after the timeout
        evt_ready = 1'b0;
        send(8'hF0);
        repeat (TO + 5) @(posedge clk);
        expect_evt(1'b1, 0);
        send(8'h29);
        settle();
        check("post_timeout_make", key_state, 32'h0000_0FF9);
        check("post_timeout_count", 32'(evt_count), 32'd1);

        // clear_all with keys held and an event pending; same-cycle byte dropped
        @(posedge clk); #1;
        clear_all  = 1'b1;
        scan_code  = 8'h1A;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        clear_all  = 1'b0;
        scan_valid = 1'b0;
        exp_q.delete();
        check("clr_keys", key_state, 32'h0);
        check("clr_evt_valid", 32'(evt_valid), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_count", 32'(evt_count), 32'd0);
        settle();
        check("clr_byte_dropped", key_state, 32'h0);
        expect_evt(1'b1, 0);
        send(8'h29);
        wait_drain("after_clear");

        // Async reset mid-prefix loses the E0
        send(8'hE0);
        @(posedge clk); #1;
        resetn = 1'b0;
        exp_q.delete();
        #5;
        check("rst_mid_keys", key_state, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        send(8'h75);
        settle();
        check("rst_mid_kp8", key_state, 32'h0);
        check("rst_mid_count", 32'(evt_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
